seq_feed: RTL and testbench

Instruction feeder for the `Seq` sequencer: the producing end of Seq's `inst`/`inst_en`/`next` interface. It holds a host-loaded program store of 12-bit Seq instructions. When running, it issues one instruction per cycle to Seq and fetches each following instruction from the address Seq reports on `next`. It also supports start, stop, single-step and one address breakpoint, so a host can run or debug Seq programs without driving `inst` by hand.

---
 rtl/seq_feed_pkg.sv | 25 ++
 rtl/seq_feed_mem.sv | 38 +++
 rtl/seq_feed.sv | 124 ++++++++++++
 tb/tb_seq_feed.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seq_feed_pkg.sv
// Shared Seq definitions: feeder state encodings, instruction field widths
// and the opcode subset the feeder's users reference.
package seq_feed_pkg;

  localparam int SeqOpWidth  = 4;
  localparam int SeqImmWidth = 8;

  typedef enum logic [1:0] {
    SeqFeed_Idle = 2'd0,
    SeqFeed_Run  = 2'd1,
    SeqFeed_Step = 2'd2
  } seq_feed_state_t;

  localparam logic [SeqOpWidth-1:0] Seq_NOP = 4'h0;
  localparam logic [SeqOpWidth-1:0] Seq_LDI = 4'h1;
  localparam logic [SeqOpWidth-1:0] Seq_EQI = 4'h5;

  function automatic logic [SeqOpWidth+SeqImmWidth-1:0] seq_inst(
    input logic [SeqOpWidth-1:0]  op,
    input logic [SeqImmWidth-1:0] imm
  );
    return {op, imm};
  endfunction

endpackage

// File: rtl/seq_feed_mem.sv
// Program store: synchronous RAM, one write and one read port, write-first.
// The read register holds when ren is low and is the only part reset clears.
module seq_feed_mem #(
  parameter int AddrSize = 8,
  parameter int InstSize = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wen,
  input  logic [AddrSize-1:0] waddr,
  input  logic [InstSize-1:0] wdata,
  input  logic                ren,
  input  logic [AddrSize-1:0] raddr,
  output logic [InstSize-1:0] rdata
);

  logic [InstSize-1:0] mem_r [2**AddrSize];
  logic [InstSize-1:0] rdata_r;

  // Storage array write port; no reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (wen) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register with same-address bypass of the incoming write.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (ren) begin
      rdata_r <= (wen && (waddr == raddr)) ? wdata : mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/seq_feed.sv
// Instruction feeder for Seq: runs, stops, single-steps and breaks on a
// host-loaded program, issuing one instruction per cycle on inst/inst_en.
module seq_feed
  import seq_feed_pkg::*;
#(
  parameter int AddrSize = 8,
  parameter int InstSize = SeqOpWidth + SeqImmWidth
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [AddrSize-1:0] prog_addr,
  input  logic [InstSize-1:0] prog_data,
  input  logic                prog_wen,
  input  logic                start,
  input  logic [AddrSize-1:0] start_addr,
  input  logic                step,
  input  logic                stop,
  input  logic                brk_en,
  input  logic [AddrSize-1:0] brk_addr,
  input  logic [AddrSize-1:0] next,
  output logic [InstSize-1:0] inst,
  output logic                inst_en,
  output logic [AddrSize-1:0] pc,
  output logic [1:0]          state,
  output logic                prog_err
);

  seq_feed_state_t     state_r, state_nxt_s;
  logic [AddrSize-1:0] raddr_s;
  logic                issue_s;
  logic                brk_hit_s;
  logic                wen_s;
  logic [AddrSize-1:0] resume_r;
  logic [AddrSize-1:0] pc_r;
  logic                inst_en_r;
  logic                prog_err_r;

  assign wen_s = prog_wen && (state_r == SeqFeed_Idle);

  // Next state, read-address mux and the "issue next cycle" decision.
  always_comb begin
    state_nxt_s = state_r;
    raddr_s     = resume_r;
    issue_s     = 1'b0;
    brk_hit_s   = brk_en && (next == brk_addr);
    case (state_r)
      SeqFeed_Idle: begin
        if (start) begin
          state_nxt_s = SeqFeed_Run;
          raddr_s     = start_addr;
          issue_s     = 1'b1;
        end else if (step) begin
          state_nxt_s = SeqFeed_Step;
          raddr_s     = resume_r;
          issue_s     = 1'b1;
        end else begin
          state_nxt_s = SeqFeed_Idle;
        end
      end
      SeqFeed_Run: begin
        raddr_s = next;
        // A breakpoint suppresses the fetch so brk_addr is never issued.
        if (stop || brk_hit_s) begin
          state_nxt_s = SeqFeed_Idle;
        end else begin
          issue_s = 1'b1;
        end
      end
      SeqFeed_Step: begin
        state_nxt_s = SeqFeed_Idle;
      end
      default: begin
        state_nxt_s = SeqFeed_Idle;
      end
    endcase
  end

  // State, resume/pc registers, issue strobe and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= SeqFeed_Idle;
      resume_r   <= '0;
      pc_r       <= '0;
      inst_en_r  <= 1'b0;
      prog_err_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      inst_en_r <= issue_s;
      if (issue_s) begin
        pc_r <= raddr_s;
      end
      // next always names the first unissued address, so stop and break
      // both leave resume pointing where execution should continue.
      if ((state_r == SeqFeed_Idle) && start) begin
        resume_r <= start_addr;
      end else if (inst_en_r) begin
        resume_r <= next;
      end
      if (prog_wen && (state_r != SeqFeed_Idle)) begin
        prog_err_r <= 1'b1;
      end
    end
  end

  seq_feed_mem #(
    .AddrSize(AddrSize),
    .InstSize(InstSize)
  ) u_mem (
    .clock(clock),
    .reset(reset),
    .wen  (wen_s),
    .waddr(prog_addr),
    .wdata(prog_data),
    .ren  (issue_s),
    .raddr(raddr_s),
    .rdata(inst)
  );

  assign inst_en  = inst_en_r;
  assign pc       = pc_r;
  assign state    = state_r;
  assign prog_err = prog_err_r;

endmodule

// File: tb/tb_seq_feed.sv
// Scoreboard bench for seq_feed: directed program loads and run/step/break
// sequences push expected {pc, inst}; a negedge monitor checks each issue.
module tb_seq_feed;
  import seq_feed_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data;
  logic        prog_wen;
  logic        start;
  logic [7:0]  start_addr;
  logic        step;
  logic        stop;
  logic        brk_en;
  logic [7:0]  brk_addr;
  logic [7:0]  next;
  logic [11:0] inst;
  logic        inst_en;
  logic [7:0]  pc;
  logic [1:0]  state;
  logic        prog_err;

  logic        jump_en;
  logic [7:0]  jump_addr;

  int n_cmp = 0;
  int n_bad = 0;
  logic [19:0] exp_q[$];
  logic [11:0] em [256];

  seq_feed dut (
    .clock(clock), .reset(reset), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_wen(prog_wen), .start(start), .start_addr(start_addr), .step(step),
    .stop(stop), .brk_en(brk_en), .brk_addr(brk_addr), .next(next),
    .inst(inst), .inst_en(inst_en), .pc(pc), .state(state), .prog_err(prog_err)
  );

  always #5 clock = ~clock;

  // Seq model: fall through to pc+1 unless a jump is being forced.
  assign next = jump_en ? jump_addr : pc + 8'd1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a);
    exp_q.push_back({a, em[a]});
  endtask

  task automatic wr(input logic [7:0] a, input logic [11:0] d);
    prog_addr = a; prog_data = d; prog_wen = 1'b1; em[a] = d;
    tick();
    prog_wen = 1'b0;
  endtask

  // Monitor: every issued instruction must match the head of the scoreboard.
  always @(negedge clock) begin
    if (inst_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_issue: pc 'h%0h inst 'h%0h, none expected", pc, inst);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("issue_pc", int'(pc), int'(e[19:12]));
        check("issue_inst", int'(inst), int'(e[11:0]));
      end
    end
  end

  initial begin
    reset = 1'b1; prog_addr = 8'h00; prog_data = 12'h000; prog_wen = 1'b0;
    start = 1'b0; start_addr = 8'h00; step = 1'b0; stop = 1'b0;
    brk_en = 1'b0; brk_addr = 8'h00; jump_en = 1'b0; jump_addr = 8'h00;
    tick(); tick();
    reset = 1'b0;
    check("rst_inst_en", int'(inst_en), 0);
    check("rst_inst", int'(inst), 0);
    check("rst_pc", int'(pc), 0);
    check("rst_state", int'(state), 0);
    check("rst_prog_err", int'(prog_err), 0);

    wr(8'h10, 12'h1FA);   // LDI 0xFA
    wr(8'h11, 12'h000);   // NOP
    wr(8'h12, 12'h2A5);
    wr(8'h13, 12'h3C3);
    wr(8'h1A, 12'h7E1);
    wr(8'h1B, 12'h844);

    // Run from 0x10, fall through, then jump to 0x1A with no gap.
    start = 1'b1; start_addr = 8'h10; push(8'h10);
    tick(); start = 1'b0;
    check("run_state", int'(state), 1);
    push(8'h11); tick();
    push(8'h12); tick();
    jump_en = 1'b1; jump_addr = 8'h1A; push(8'h1A);
    tick(); jump_en = 1'b0;
    check("jump_inst_en", int'(inst_en), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_inst_en", int'(inst_en), 0);
    check("stop_state", int'(state), 0);
    check("idle_hold_pc", int'(pc), 'h1A);
    // Resume is the unissued 0x1B.
    step = 1'b1; push(8'h1B); tick(); step = 1'b0;
    check("step_state", int'(state), 2);
    tick();
    check("step_done_en", int'(inst_en), 0);
    check("step_done_state", int'(state), 0);

    // Breakpoint at 0x12: 0x10, 0x11 issued, then Idle; step issues 0x12.
    brk_en = 1'b1; brk_addr = 8'h12;
    start = 1'b1; start_addr = 8'h10; push(8'h10); tick(); start = 1'b0;
    push(8'h11); tick();
    tick();
    check("brk_state", int'(state), 0);
    check("brk_inst_en", int'(inst_en), 0);
    step = 1'b1; push(8'h12); tick(); step = 1'b0;
    tick();
    check("brk_step_state", int'(state), 0);
    brk_en = 1'b0;

    // Write during Run is dropped and flags prog_err.
    start = 1'b1; start_addr = 8'h10; push(8'h10); tick(); start = 1'b0;
    prog_addr = 8'h11; prog_data = 12'hFFF; prog_wen = 1'b1; push(8'h11);
    tick(); prog_wen = 1'b0;
    check("prog_err_set", int'(prog_err), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
    check("prog_err_sticky", int'(prog_err), 1);
    start = 1'b1; start_addr = 8'h11; push(8'h11); tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // Reset mid-Run clears outputs but keeps memory.
    start = 1'b1; start_addr = 8'h10; push(8'h10); tick(); start = 1'b0;
    push(8'h11); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_inst_en", int'(inst_en), 0);
    check("mid_rst_inst", int'(inst), 0);
    check("mid_rst_pc", int'(pc), 0);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_prog_err", int'(prog_err), 0);
    start = 1'b1; start_addr = 8'h10; push(8'h10); tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;

    // Write-first: write and start at 0x20 in the same cycle.
    prog_addr = 8'h20; prog_data = 12'h510; prog_wen = 1'b1; em[8'h20] = 12'h510;
    start = 1'b1; start_addr = 8'h20; push(8'h20);
    tick(); start = 1'b0; prog_wen = 1'b0;
    check("wf_prog_err", int'(prog_err), 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // start and step together: start wins.
    start = 1'b1; step = 1'b1; start_addr = 8'h13; push(8'h13);
    tick(); start = 1'b0; step = 1'b0;
    check("start_wins_state", int'(state), 1);
    stop = 1'b1; tick(); stop = 1'b0;
    tick();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
